// File: rtl/fft_pkg.sv
// fft_pkg: shared types and helpers for the FFT frame sequencer.
//   state_e          - sequencer state encoding (3 bits, IDLE..OUTPUT)
//   STAGE0..STAGE7   - stage index constants
//   BEATS            - beats per frame for the default 32-point, 4-lane build
//   clog2 / is_pow2  - constant functions used by the elaboration checks
package fft_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LDRAM   = 3'd1,
        RAMRDY  = 3'd2,
        RUNNING = 3'd3,
        DONE    = 3'd4,
        OUTPUT  = 3'd5
    } state_e;

    localparam int unsigned STAGE0 = 0;
    localparam int unsigned STAGE1 = 1;
    localparam int unsigned STAGE2 = 2;
    localparam int unsigned STAGE3 = 3;
    localparam int unsigned STAGE4 = 4;
    localparam int unsigned STAGE5 = 5;
    localparam int unsigned STAGE6 = 6;
    localparam int unsigned STAGE7 = 7;

    localparam int unsigned DEF_NUMSAMPLES = 32;
    localparam int unsigned DEF_LANES      = 4;
    localparam int unsigned BEATS          = DEF_NUMSAMPLES / DEF_LANES;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) r = i + 1;
        end
        return r;
    endfunction

    function automatic bit is_pow2(input int unsigned v);
        return (v != 0) && ((v & (v - 1)) == 0);
    endfunction

endpackage

// File: rtl/fft_beat_counter.sv
// fft_beat_counter: output beat address counter for the result drain.
//   clk, rst_n - clock, asynchronous active-low reset
//   clr        - synchronous clear to 0 (wins over adv)
//   adv        - advance by one beat, wrapping after BEATS-1
//   addr       - current beat index
//   tc         - terminal count, high while addr == BEATS-1
module fft_beat_counter
    import fft_pkg::*;
#(
    parameter int unsigned ADDRSIZE = 3,
    parameter int unsigned BEATS    = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr,
    input  logic                adv,
    output logic [ADDRSIZE-1:0] addr,
    output logic                tc
);

    localparam logic [ADDRSIZE-1:0] LAST = ADDRSIZE'(BEATS - 1);

    if (ADDRSIZE != clog2(BEATS)) begin : g_chk_width
        $error("fft_beat_counter: ADDRSIZE must equal log2(BEATS)");
    end

    logic [ADDRSIZE-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (adv) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign addr = cnt_q;
    assign tc   = (cnt_q == LAST);

endmodule

// File: rtl/fft_seq_ctrl.sv
// fft_seq_ctrl: frame sequencer for the multi-stage FFT datapath.
// Flow: IDLE -> LDRAM -> RAMRDY -> RUNNING (stage 0..NUMSTAGES-1) -> DONE
//       -> OUTPUT (ready/valid drain) -> IDLE, or LDRAM when cont_mode=1.
// Ports:
//   clk, rst_n        - clock, asynchronous active-low reset
//   start             - begin a frame (IDLE only)
//   abort             - return to IDLE next cycle from any state
//   cont_mode         - after the last beat, reload instead of idling
//   ld_data / ld_done - loader enable / loader finished
//   stage_en/stage_sel/stage_done - one-hot stage enable, index, finished
//   done              - one-cycle pulse when the last stage completes
//   out_valid/out_ready/out_addr/out_last - result drain handshake
//   busy, frame_cnt   - not-idle flag, completed frame counter (wraps)
//   error             - sticky watchdog error
// Build option: define FFT_SEQ_WDOG_EN to add the LDRAM/RUNNING watchdog
// (parameter WDOG_CYCLES); without it error is tied to 0.
// All outputs are decoded from registers only.
module fft_seq_ctrl
    import fft_pkg::*;
#(
    parameter int unsigned WORDSIZE   = 16,
    parameter int unsigned NUMSAMPLES = 32,
    parameter int unsigned LANES      = 4,
    parameter int unsigned NUMSTAGES  = 5,
    parameter int unsigned STAGEW     = 3,
    parameter int unsigned ADDRSIZE   = 3,
    parameter int unsigned FRAMEW     = 8
`ifdef FFT_SEQ_WDOG_EN
    ,
    parameter int unsigned WDOG_CYCLES = 1024
`endif
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 cont_mode,
    output logic                 ld_data,
    input  logic                 ld_done,
    output logic [NUMSTAGES-1:0] stage_en,
    output logic [STAGEW-1:0]    stage_sel,
    input  logic                 stage_done,
    output logic                 done,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ADDRSIZE-1:0]  out_addr,
    output logic                 out_last,
    output logic                 busy,
    output logic [FRAMEW-1:0]    frame_cnt,
    output logic                 error
);

    localparam int unsigned        BEAT_CNT   = NUMSAMPLES / LANES;
    localparam logic [STAGEW-1:0]  LAST_STAGE = STAGEW'(NUMSTAGES - 1);

    if (!is_pow2(NUMSAMPLES) || !is_pow2(LANES) || (NUMSAMPLES % LANES) != 0) begin : g_chk_size
        $error("fft_seq_ctrl: NUMSAMPLES and LANES must be powers of 2, LANES dividing NUMSAMPLES");
    end
    if (NUMSTAGES != clog2(NUMSAMPLES)) begin : g_chk_stages
        $error("fft_seq_ctrl: NUMSTAGES must equal log2(NUMSAMPLES)");
    end
    if ((64'd1 << STAGEW) < 64'(NUMSTAGES)) begin : g_chk_stagew
        $error("fft_seq_ctrl: STAGEW too narrow for NUMSTAGES");
    end
    if (ADDRSIZE != clog2(BEAT_CNT)) begin : g_chk_addr
        $error("fft_seq_ctrl: ADDRSIZE must equal log2(NUMSAMPLES/LANES)");
    end
    if (WORDSIZE == 0) begin : g_chk_word
        $error("fft_seq_ctrl: WORDSIZE must be non-zero");
    end

    state_e                 state_q, state_d;
    logic [STAGEW-1:0]      stage_sel_q, stage_sel_d;
    logic [FRAMEW-1:0]      frame_cnt_q, frame_cnt_d;
    logic [NUMSTAGES-1:0]   stage_en_q, stage_en_d;
    logic                   ld_data_q, ld_data_d;
    logic                   done_q, done_d;
    logic                   out_valid_q, out_valid_d;
    logic                   busy_q, busy_d;

    logic                   xfer, final_beat, beat_tc, kill, wdog_trip;
    logic [ADDRSIZE-1:0]    beat_addr;

    assign xfer       = out_valid_q & out_ready;
    assign final_beat = xfer & beat_tc;
    assign kill       = abort | wdog_trip;

`ifdef FFT_SEQ_WDOG_EN
    localparam int unsigned WDW = clog2(WDOG_CYCLES) + 1;

    if (WDOG_CYCLES == 0) begin : g_chk_wdog
        $error("fft_seq_ctrl: WDOG_CYCLES must be non-zero");
    end

    logic [WDW-1:0] wdog_q, wdog_d;
    logic           error_q, error_d;

    // Counter value is the number of cycles already spent in the current
    // state/stage, so the trip fires at the end of the WDOG_CYCLES-th cycle.
    assign wdog_trip = (state_q == LDRAM || state_q == RUNNING) &&
                       (wdog_q == WDW'(WDOG_CYCLES - 1));

    always_comb begin
        wdog_d = wdog_q;
        if (state_d != state_q || stage_sel_d != stage_sel_q) begin
            wdog_d = '0;
        end else if (state_q == LDRAM || state_q == RUNNING) begin
            wdog_d = wdog_q + 1'b1;
        end
        error_d = error_q | wdog_trip;
    end

    assign error = error_q;
`else
    assign wdog_trip = 1'b0;
    assign error     = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        stage_sel_d = stage_sel_q;
        frame_cnt_d = frame_cnt_q;

        case (state_q)
            IDLE:    if (start) state_d = LDRAM;
            LDRAM:   if (ld_done) state_d = RAMRDY;
            RAMRDY: begin
                state_d     = RUNNING;
                stage_sel_d = STAGEW'(STAGE0);
            end
            RUNNING: begin
                if (stage_done) begin
                    if (stage_sel_q == LAST_STAGE) state_d = DONE;
                    else                           stage_sel_d = stage_sel_q + 1'b1;
                end
            end
            DONE:    state_d = OUTPUT;
            OUTPUT: begin
                if (final_beat) begin
                    frame_cnt_d = frame_cnt_q + 1'b1;
                    state_d     = cont_mode ? LDRAM : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Abort / watchdog override everything decided above.
        if (kill) begin
            state_d     = IDLE;
            stage_sel_d = STAGEW'(STAGE0);
            frame_cnt_d = frame_cnt_q;
        end

        // Outputs are registered copies of the next-state decode.
        ld_data_d   = (state_d == LDRAM);
        stage_en_d  = (state_d == RUNNING) ? (NUMSTAGES'(1) << stage_sel_d) : '0;
        done_d      = (state_d == DONE);
        out_valid_d = (state_d == OUTPUT);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            stage_sel_q <= '0;
            frame_cnt_q <= '0;
            stage_en_q  <= '0;
            ld_data_q   <= 1'b0;
            done_q      <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef FFT_SEQ_WDOG_EN
            wdog_q      <= '0;
            error_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            stage_sel_q <= stage_sel_d;
            frame_cnt_q <= frame_cnt_d;
            stage_en_q  <= stage_en_d;
            ld_data_q   <= ld_data_d;
            done_q      <= done_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
`ifdef FFT_SEQ_WDOG_EN
            wdog_q      <= wdog_d;
            error_q     <= error_d;
`endif
        end
    end

    // Held at 0 outside OUTPUT so the first beat of every frame is 0.
    fft_beat_counter #(
        .ADDRSIZE (ADDRSIZE),
        .BEATS    (BEAT_CNT)
    ) u_beat_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (kill | (state_q != OUTPUT)),
        .adv   (xfer),
        .addr  (beat_addr),
        .tc    (beat_tc)
    );

    assign ld_data   = ld_data_q;
    assign stage_en  = stage_en_q;
    assign stage_sel = stage_sel_q;
    assign done      = done_q;
    assign out_valid = out_valid_q;
    assign out_addr  = beat_addr;
    assign out_last  = out_valid_q & beat_tc;
    assign busy      = busy_q;
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_fft_seq_ctrl.sv
// tb_fft_seq_ctrl: self-checking bench for fft_seq_ctrl (default 32-point,
// 4-lane, 5-stage build). Expected output beats are queued when a frame is
// started and compared as the DUT hands them over. Define FFT_SEQ_WDOG_EN
// to also exercise the watchdog with WDOG_CYCLES=16.
module tb_fft_seq_ctrl;
    import fft_pkg::*;

    localparam int unsigned NST = 5;
    localparam int unsigned STW = 3;
    localparam int unsigned AW  = 3;
    localparam int unsigned FW  = 8;
    localparam int unsigned NB  = BEATS;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0, abort = 1'b0, cont_mode = 1'b0;
    logic           ld_done = 1'b0, stage_done = 1'b0, out_ready = 1'b0;
    logic           ld_data, done, out_valid, out_last, busy, error;
    logic [NST-1:0] stage_en;
    logic [STW-1:0] stage_sel;
    logic [AW-1:0]  out_addr;
    logic [FW-1:0]  frame_cnt;

    always #5 clk = ~clk;

    fft_seq_ctrl #(
        .WORDSIZE   (16),
        .NUMSAMPLES (32),
        .LANES      (4),
        .NUMSTAGES  (NST),
        .STAGEW     (STW),
        .ADDRSIZE   (AW),
        .FRAMEW     (FW)
`ifdef FFT_SEQ_WDOG_EN
        ,
        .WDOG_CYCLES (16)
`endif
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .cont_mode  (cont_mode),
        .ld_data    (ld_data),
        .ld_done    (ld_done),
        .stage_en   (stage_en),
        .stage_sel  (stage_sel),
        .stage_done (stage_done),
        .done       (done),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_addr   (out_addr),
        .out_last   (out_last),
        .busy       (busy),
        .frame_cnt  (frame_cnt),
        .error      (error)
    );

    typedef struct packed {
        logic [AW-1:0] addr;
        logic          last;
    } beat_t;

    beat_t       sb_q[$];
    int unsigned n_tests = 0, n_fail = 0;
    int unsigned done_cnt = 0, busy_drop = 0, exp_frames = 0;
    bit          watch_busy = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Inputs change at posedge+1, so negedge sees the values the next edge uses.
    always @(negedge clk) begin
        if (rst_n) begin
            if (done) done_cnt++;
            if (watch_busy && !busy) busy_drop++;
            if (out_valid && out_ready) begin
                chk("sb_nonempty", 32'(sb_q.size() > 0), 32'd1);
                if (sb_q.size() > 0) begin
                    beat_t e;
                    e = sb_q.pop_front();
                    chk("beat_addr", 32'(out_addr), 32'(e.addr));
                    chk("beat_last", 32'(out_last), 32'(e.last));
                end
            end
        end
    end

    task automatic push_frame();
        beat_t b;
        for (int unsigned i = 0; i < NB; i++) begin
            b.addr = AW'(i);
            b.last = (i == NB - 1);
            sb_q.push_back(b);
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; ld_done = 1'b0;
        stage_done = 1'b0; out_ready = 1'b0; cont_mode = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
        exp_frames = 0;
        sb_q.delete();
    endtask

    // mode: 0 normal, 1 abort with last stage_done, 2 abort on final beat,
    //       3 async reset in the middle of OUTPUT
    task automatic run_frame(input bit do_start, input bit cont, input int unsigned mode,
                             input bit bp, input bit spur);
        int unsigned d0, beats, n;
        bit          rdy;
        d0 = done_cnt;
        cont_mode = cont;
        if (mode != 1) push_frame();
        if (do_start) begin
            start = 1'b1; tick(); start = 1'b0;
        end
        chk("ldram_ld_data", 32'(ld_data), 32'd1);
        chk("ldram_busy", 32'(busy), 32'd1);
        repeat (7) tick();
        ld_done = 1'b1; tick(); ld_done = 1'b0;
        chk("ramrdy_ld_data", 32'(ld_data), 32'd0);
        chk("ramrdy_stage_en", 32'(stage_en), 32'd0);
        tick();
        for (int unsigned s = 0; s < NST; s++) begin
            chk("stage_en", 32'(stage_en), 32'd1 << s);
            chk("stage_sel", 32'(stage_sel), s);
            if (spur && s == 1) start = 1'b1;
            tick(); start = 1'b0;
            tick();
            stage_done = 1'b1;
            if (mode == 1 && s == NST - 1) abort = 1'b1;
            tick();
            stage_done = 1'b0; abort = 1'b0;
            if (mode == 1 && s == NST - 1) begin
                chk("abort_stg_busy", 32'(busy), 32'd0);
                chk("abort_stg_en", 32'(stage_en), 32'd0);
                chk("abort_stg_sel", 32'(stage_sel), 32'd0);
                tick();
                chk("abort_stg_done", done_cnt - d0, 32'd0);
                chk("abort_stg_frames", 32'(frame_cnt), exp_frames % 256);
                return;
            end
        end
        chk("done_pulse", 32'(done), 32'd1);
        chk("done_stage_en", 32'(stage_en), 32'd0);
        chk("done_valid", 32'(out_valid), 32'd0);
        tick();
        chk("done_fall", 32'(done), 32'd0);
        chk("first_valid", 32'(out_valid), 32'd1);
        chk("first_addr", 32'(out_addr), 32'd0);

        beats = 0; n = 0;
        while (beats < NB && n < 64) begin
            if (mode == 3 && beats == 3) begin
                rst_n = 1'b0;
                #1;
                chk("rst_valid", 32'(out_valid), 32'd0);
                chk("rst_addr", 32'(out_addr), 32'd0);
                chk("rst_busy", 32'(busy), 32'd0);
                chk("rst_frames", 32'(frame_cnt), 32'd0);
                chk("rst_strobes", 32'({ld_data, done, out_last, error, stage_en}), 32'd0);
                out_ready = 1'b0;
                sb_q.delete();
                exp_frames = 0;
                tick();
                rst_n = 1'b1;
                tick();
                return;
            end
            rdy = bp ? ((n % 4) == 0 || (n % 4) == 3) : 1'b1;
            out_ready = rdy;
            if (mode == 2 && beats == NB - 1 && rdy) abort = 1'b1;
            if (!rdy) begin
                chk("stall_valid", 32'(out_valid), 32'd1);
                chk("stall_addr", 32'(out_addr), beats);
                chk("stall_last", 32'(out_last), 32'(beats == NB - 1));
            end
            if (rdy && out_valid) beats++;
            tick();
            n++;
        end
        out_ready = 1'b0;
        abort = 1'b0;
        chk("drain_beats", beats, NB);
        if (mode == 2) begin
            chk("abort_last_busy", 32'(busy), 32'd0);
            chk("abort_last_addr", 32'(out_addr), 32'd0);
        end else begin
            exp_frames++;
            if (cont) chk("cont_reload", 32'(ld_data), 32'd1);
            else      chk("end_idle", 32'(busy), 32'd0);
        end
        chk("end_valid", 32'(out_valid), 32'd0);
        chk("frame_cnt", 32'(frame_cnt), exp_frames % 256);
        chk("done_once", done_cnt - d0, 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "time limit reached");
    end

    initial begin
        int unsigned n;

        tick(); tick();
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_strobes", 32'({ld_data, done, out_valid, out_last, error}), 32'd0);
        chk("reset_stage", 32'({stage_en, stage_sel}), 32'd0);
        chk("reset_addr", 32'(out_addr), 32'd0);
        chk("reset_frames", 32'(frame_cnt), 32'd0);
        rst_n = 1'b1;
        tick();

        // spurious loader / stage completions while idle
        ld_done = 1'b1; stage_done = 1'b1;
        repeat (3) tick();
        ld_done = 1'b0; stage_done = 1'b0;
        chk("spur_idle_busy", 32'(busy), 32'd0);
        chk("spur_idle_ld", 32'(ld_data), 32'd0);
        chk("spur_idle_en", 32'(stage_en), 32'd0);

        run_frame(1'b1, 1'b0, 0, 1'b0, 1'b0);   // nominal
        run_frame(1'b1, 1'b0, 0, 1'b1, 1'b1);   // back-pressure, start in RUNNING
        run_frame(1'b1, 1'b0, 1, 1'b0, 1'b0);   // abort with last stage_done
        run_frame(1'b1, 1'b0, 2, 1'b0, 1'b0);   // abort on final beat
        run_frame(1'b1, 1'b0, 3, 1'b0, 1'b0);   // reset inside OUTPUT

        apply_reset();
        run_frame(1'b1, 1'b1, 0, 1'b0, 1'b0);
        watch_busy = 1'b1;
        run_frame(1'b0, 1'b1, 0, 1'b0, 1'b0);
        run_frame(1'b0, 1'b0, 0, 1'b0, 1'b0);
        watch_busy = 1'b0;
        chk("cont_busy_drop", busy_drop, 32'd0);
        chk("cont_frames", 32'(frame_cnt), 32'd3);

`ifdef FFT_SEQ_WDOG_EN
        apply_reset();
        start = 1'b1; tick(); start = 1'b0;
        repeat (7) tick();
        ld_done = 1'b1; tick(); ld_done = 1'b0;
        tick();
        for (int unsigned s = 0; s < 2; s++) begin
            repeat (2) tick();
            stage_done = 1'b1; tick(); stage_done = 1'b0;
        end
        chk("wd_stage2", 32'(stage_en), 32'd4);
        n = 0;
        while (!error && n < 40) begin
            tick();
            n++;
        end
        chk("wd_cycles", n, 32'd16);
        chk("wd_idle", 32'(busy), 32'd0);
        repeat (5) tick();
        chk("wd_sticky", 32'(error), 32'd1);
        apply_reset();
        chk("wd_cleared", 32'(error), 32'd0);
`else
        n = 0;
        chk("error_tied", 32'(error), 32'(n));
`endif

        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fft_seq_ctrl.md
Name: fft_seq_ctrl

Overview:
Parametrised control sequencer for the multi-stage FFT datapath. Runs the frame flow: load RAM, then run stages 0..NUMSTAGES-1 in sequence, pulse done, then drain results with a ready/valid output handshake. Sits between the system/host and the fft_stage instances plus the read_input loader. Adds frame counting, abort, back-pressure on output and optional continuous mode.

Parameters:
WORDSIZE, 16, sample word width (passed through for consistency checks only)
NUMSAMPLES, 32, points per frame; power of 2
LANES, 4, words moved per cycle; power of 2; must divide NUMSAMPLES
NUMSTAGES, 5, number of FFT stages; equals log2(NUMSAMPLES)
STAGEW, 3, width of stage index; 2**STAGEW >= NUMSTAGES
ADDRSIZE, 3, beat address width; equals log2(NUMSAMPLES/LANES)
FRAMEW, 8, frame counter width

Ports:
clk  in  1  clock; all logic on posedge
rst_n  in  1  asynchronous active-low reset
start  in  1  begin a frame; sampled only in IDLE
abort  in  1  synchronous abort; any state -> IDLE next cycle
cont_mode  in  1  when 1, return to LDRAM after OUTPUT instead of IDLE
ld_data  out  1  loader enable; high throughout LDRAM
ld_done  in  1  loader finished; sampled only in LDRAM
stage_en  out  NUMSTAGES  one-hot enable of the active stage; 0 outside RUNNING
stage_sel  out  STAGEW  index of the active stage
stage_done  in  1  active stage finished; sampled only in RUNNING
done  out  1  one-cycle pulse when the last stage completes
out_valid  out  1  output beat valid
out_ready  in  1  downstream accepts beat
out_addr  out  ADDRSIZE  beat index 0..NUMSAMPLES/LANES-1
out_last  out  1  high with the final beat of a frame
busy  out  1  high in every state except IDLE
frame_cnt  out  FRAMEW  completed frames; wraps modulo 2**FRAMEW
error  out  1  sticky; cleared only by reset (see Optional Feature)

Behaviour:
- States: IDLE, LDRAM, RAMRDY, RUNNING, DONE, OUTPUT. Encoding is in the package. All outputs are decoded from registered state and counters (Moore); no combinational input-to-output paths.
- Reset: state IDLE. ld_data, stage_en, stage_sel, done, out_valid, out_addr, out_last, busy, frame_cnt and error are all 0.
- IDLE: start=1 -> LDRAM. ld_data rises on the first cycle in LDRAM (1 cycle after start is sampled).
- LDRAM: ld_data=1. ld_done=1 -> RAMRDY. ld_done is ignored in every other state.
- RAMRDY: held for exactly 1 cycle. stage_sel is loaded with 0. Next state is RUNNING.
- RUNNING: stage_en = 1 << stage_sel.
  - stage_done with stage_sel < NUMSTAGES-1: stage_sel increments next cycle; state stays RUNNING.
  - stage_done with stage_sel = NUMSTAGES-1: -> DONE.
  - stage_done outside RUNNING is ignored.
- DONE: held for 1 cycle. done=1 during that cycle only. Next state is OUTPUT with out_addr=0.
- OUTPUT: out_valid=1. A beat transfers when out_valid & out_ready; out_addr increments after each transfer.
  - out_valid, out_addr and out_last are held stable while out_ready=0.
  - out_last = (out_addr == NUMSAMPLES/LANES-1).
  - On the final transfer, frame_cnt increments (wrapping) and the state goes to LDRAM if cont_mode=1, else IDLE.
  - cont_mode is sampled on the final transfer cycle only.
- abort: overrides every other transition, including a simultaneous stage_done, ld_done or final beat.
  - Next cycle: state IDLE, all strobes 0, stage_sel 0, out_addr 0.
  - frame_cnt is not incremented; error is unchanged.
- Total latency, start to first out_valid: 1 + load + 1 + sum(stage times) + 1 cycles.
- Reset mid-operation: asynchronous return to the reset values above.

Optional Feature:
FFT_SEQ_WDOG_EN
- Defined: adds parameter WDOG_CYCLES (default 1024) and an internal counter.
  - The counter clears on every state change and on every stage_sel increment, and counts otherwise while in LDRAM or RUNNING.
  - When it reaches WDOG_CYCLES: error is set (sticky) and state goes to IDLE next cycle, handled like abort.
- Not defined: no counter; error is tied to 0.

Decomposition:
- Package fft_pkg holds:
  - state encodings (3-bit: IDLE..OUTPUT)
  - stage index constants STAGE0..STAGE7
  - a clog2 function
  - derived constant BEATS = NUMSAMPLES/LANES
  - elaboration checks (power-of-2 sizes, NUMSTAGES = log2(NUMSAMPLES))
- One sub-module, fft_beat_counter: ADDRSIZE-wide counter with clear, advance and a terminal-count flag. Used for the out_addr drain.

Test Plan:
- Nominal frame: reset, start, ld_done after 8 cycles, stage_done after 3 cycles per stage, out_ready=1 -> stage_en walks 00001..10000; done pulses once; 8 beats with out_addr 0..7; out_last on beat 7; frame_cnt=1; state returns to IDLE.
- Back-pressure: during OUTPUT, out_ready toggles 1,0,0,1,... -> out_addr/out_last hold while stalled; exactly 8 transfers; frame_cnt increments once.
- Continuous mode: cont_mode=1, run 3 frames -> LDRAM is re-entered with no IDLE cycle between frames; frame_cnt=3; busy stays high throughout.
- Abort collisions:
  - abort together with stage_done on stage 4 -> IDLE; no done pulse; frame_cnt unchanged.
  - abort on the final beat -> frame_cnt unchanged.
- Spurious inputs and reset:
  - ld_done and stage_done in IDLE -> no state change.
  - start during RUNNING -> ignored.
  - rst_n low in OUTPUT -> all outputs 0 immediately (asynchronously).
- Watchdog (FFT_SEQ_WDOG_EN defined, WDOG_CYCLES=16): stage_done withheld in stage 2 -> error=1 after 16 cycles, IDLE next cycle, error stays 1 until reset.
